// File: rtl/floo_pkg.sv
// Shared types for the ID/destination tracker.
// Holds the flush state encoding.
package floo_pkg;

  typedef enum logic [1:0] {
    FLUSH_RUN   = 2'd0,
    FLUSH_DRAIN = 2'd1,
    FLUSH_DONE  = 2'd2
  } flush_state_e;

endpackage

// File: rtl/floo_id_dest_slot.sv
// One tracking slot: routing fields plus a
// count of last-responses still expected.
module floo_id_dest_slot
  import floo_pkg::*;
#(
  parameter type dest_t = logic,
  parameter type select_t = logic,
  parameter int unsigned RepW = 3,
  parameter int unsigned CntW = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic            mcast_i,
  input  dest_t           dest_i,
  input  select_t         select_i,
  input  logic [RepW-1:0] rep_i,
  output logic            occupied_o,
  output logic            mcast_o,
  output dest_t           dest_o,
  output select_t         select_o,
  output logic [RepW-1:0] rep_o,
  output logic [CntW-1:0] cnt_o
);

  logic            occupied_q;
  logic            mcast_q;
  dest_t           dest_q;
  select_t         select_q;
  logic [RepW-1:0] rep_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_d;
  logic            pop_ok;

  // next count; a pop on an empty count is ignored
  always_comb begin
    pop_ok = pop_i && (cnt_q != '0);
    cnt_d  = cnt_q;
    if (push_i) cnt_d = cnt_d + CntW'(rep_i);
    if (pop_ok) cnt_d = cnt_d - CntW'(1);
  end

  // slot registers; fields load only when slot was free
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occupied_q <= 1'b0;
      mcast_q    <= 1'b0;
      dest_q     <= '0;
      select_q   <= '0;
      rep_q      <= '0;
      cnt_q      <= '0;
    end else begin
      if (push_i && !occupied_q) begin
        mcast_q  <= mcast_i;
        dest_q   <= dest_i;
        select_q <= select_i;
        rep_q    <= rep_i;
      end
      cnt_q      <= cnt_d;
      occupied_q <= (cnt_d != '0);
    end
  end

  assign occupied_o = occupied_q;
  assign mcast_o    = mcast_q;
  assign dest_o     = dest_q;
  assign select_o   = select_q;
  assign rep_o      = rep_q;
  assign cnt_o      = cnt_q;

endmodule

// File: rtl/floo_id_dest_tracker.sv
// Blocks requests whose ID slot is bound to a
// different destination until responses drain.
module floo_id_dest_tracker
  import floo_pkg::*;
#(
  parameter int unsigned IdWidth = 4,
  parameter int unsigned SlotIdxBits = 2,
  parameter int unsigned MaxRspPerId = 32,
  parameter int unsigned MaxRepCoeff = 4,
  parameter type dest_t = logic,
  parameter type select_t = logic
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           ax_valid_i,
  output logic                           ax_ready_o,
  input  logic [IdWidth-1:0]             ax_id_i,
  input  logic                           ax_mcast_i,
  input  dest_t                          ax_dest_i,
  input  select_t                        ax_select_i,
  input  logic [$clog2(MaxRepCoeff):0]   ax_rep_coeff_i,
  output logic                           ax_valid_o,
  input  logic                           ax_ready_i,
  input  logic                           rsp_valid_i,
  output logic                           rsp_ready_o,
  input  logic [IdWidth-1:0]             rsp_id_i,
  input  logic                           rsp_last_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  input  logic                           flush_i,
  output logic                           idle_o,
  output logic                           stall_o,
  output logic                           err_o
);

  localparam int unsigned NumSlots = 1 << SlotIdxBits;
  localparam int unsigned RepW = $clog2(MaxRepCoeff) + 1;
  localparam int unsigned CntW = $clog2(MaxRspPerId + 1);
  localparam int unsigned SumW = ((CntW > RepW) ? CntW : RepW) + 1;

  if (SlotIdxBits > IdWidth) begin : g_bad_idx
    $error("SlotIdxBits must not exceed IdWidth");
  end
  if (MaxRepCoeff > MaxRspPerId) begin : g_bad_rep
    $error("MaxRepCoeff must not exceed MaxRspPerId");
  end

  logic [NumSlots-1:0]           occ;
  logic [NumSlots-1:0]           mc;
  dest_t                         dst [NumSlots];
  select_t                       sel [NumSlots];
  logic [NumSlots-1:0][RepW-1:0] rep;
  logic [NumSlots-1:0][CntW-1:0] cnt;
  logic [NumSlots-1:0]           push_s;
  logic [NumSlots-1:0]           pop_s;

  logic [SlotIdxBits-1:0] ax_slot;
  logic [SlotIdxBits-1:0] rsp_slot;
  logic                   match;
  logic                   room;
  logic                   eligible;
  logic                   push;
  logic                   pop;
  logic                   err_q;
  logic                   flush_active;
  logic                   unused_bits;

  flush_state_e state_q, state_d;

  assign ax_slot  = ax_id_i[SlotIdxBits-1:0];
  assign rsp_slot = rsp_id_i[SlotIdxBits-1:0];

  // eligibility from registered slot state only
  always_comb begin
    match = (mc[ax_slot] == ax_mcast_i) &&
            (ax_mcast_i ? (sel[ax_slot] == ax_select_i)
                        : (dst[ax_slot] == ax_dest_i));
    room  = (SumW'(cnt[ax_slot]) + SumW'(ax_rep_coeff_i))
            <= SumW'(MaxRspPerId);
    eligible = !flush_active && (ax_rep_coeff_i != '0) &&
               (!occ[ax_slot] || match) && room;
  end

  assign ax_valid_o  = ax_valid_i && eligible;
  assign ax_ready_o  = eligible && ax_ready_i;
  assign stall_o     = ax_valid_i && !eligible;
  assign push        = ax_valid_o && ax_ready_i;
  assign pop         = rsp_valid_i && rsp_ready_i && rsp_last_i;
  assign rsp_valid_o = rsp_valid_i;
  assign rsp_ready_o = rsp_ready_i;
  assign idle_o      = ~|occ;
  assign err_o       = err_q;

  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    assign push_s[s] = push && (ax_slot == SlotIdxBits'(s));
    assign pop_s[s]  = pop && (rsp_slot == SlotIdxBits'(s));

    floo_id_dest_slot #(
      .dest_t   (dest_t),
      .select_t (select_t),
      .RepW     (RepW),
      .CntW     (CntW)
    ) i_slot (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (push_s[s]),
      .pop_i      (pop_s[s]),
      .mcast_i    (ax_mcast_i),
      .dest_i     (ax_dest_i),
      .select_i   (ax_select_i),
      .rep_i      (ax_rep_coeff_i),
      .occupied_o (occ[s]),
      .mcast_o    (mc[s]),
      .dest_o     (dst[s]),
      .select_o   (sel[s]),
      .rep_o      (rep[s]),
      .cnt_o      (cnt[s])
    );
  end

  // error pulse for a pop that finds nothing outstanding
  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= pop && (cnt[rsp_slot] == '0);
  end

  // flush state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FLUSH_RUN;
    else       state_q <= state_d;
  end

  // flush next state: drain until every count is zero
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FLUSH_RUN:   if (flush_i) state_d = FLUSH_DRAIN;
      FLUSH_DRAIN: if (cnt == '0) state_d = FLUSH_DONE;
      FLUSH_DONE:  if (!flush_i) state_d = FLUSH_RUN;
      default:     state_d = FLUSH_RUN;
    endcase
  end

  assign flush_active = (state_q != FLUSH_RUN);

  assign unused_bits = ^{ax_id_i, rsp_id_i, rep};

endmodule

// File: tb/tb_floo_id_dest_tracker.sv
// Randomized and directed check of the tracker
// against a queue-free per-slot count model.
module tb_floo_id_dest_tracker;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ax_valid_i, ax_ready_o, ax_mcast_i;
  logic [3:0] ax_id_i, ax_dest_i, ax_select_i;
  logic [2:0] ax_rep_coeff_i;
  logic       ax_valid_o, ax_ready_i;
  logic       rsp_valid_i, rsp_ready_o, rsp_last_i;
  logic [3:0] rsp_id_i;
  logic       rsp_valid_o, rsp_ready_i;
  logic       flush_i, idle_o, stall_o, err_o;

  int n_cmp = 0;
  int n_bad = 0;

  int         mcnt [4];
  bit         mmc  [4];
  logic [3:0] mdst [4];
  logic [3:0] msel [4];
  int         mode;
  bit         merr;

  always #5 clk_i = ~clk_i;

  floo_id_dest_tracker #(
    .IdWidth     (4),
    .SlotIdxBits (2),
    .MaxRspPerId (4),
    .MaxRepCoeff (4),
    .dest_t      (logic [3:0]),
    .select_t    (logic [3:0])
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ax_valid_i     (ax_valid_i),
    .ax_ready_o     (ax_ready_o),
    .ax_id_i        (ax_id_i),
    .ax_mcast_i     (ax_mcast_i),
    .ax_dest_i      (ax_dest_i),
    .ax_select_i    (ax_select_i),
    .ax_rep_coeff_i (ax_rep_coeff_i),
    .ax_valid_o     (ax_valid_o),
    .ax_ready_i     (ax_ready_i),
    .rsp_valid_i    (rsp_valid_i),
    .rsp_ready_o    (rsp_ready_o),
    .rsp_id_i       (rsp_id_i),
    .rsp_last_i     (rsp_last_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .flush_i        (flush_i),
    .idle_o         (idle_o),
    .stall_o        (stall_o),
    .err_o          (err_o)
  );

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit m_idle();
    for (int i = 0; i < 4; i++)
      if (mcnt[i] != 0) return 0;
    return 1;
  endfunction

  function automatic bit m_elig();
    int s;
    s = int'(ax_id_i) % 4;
    if (mode != 0) return 0;
    if (ax_rep_coeff_i == 0) return 0;
    if (mcnt[s] != 0) begin
      if (mmc[s] != ax_mcast_i) return 0;
      if (ax_mcast_i && msel[s] != ax_select_i) return 0;
      if (!ax_mcast_i && mdst[s] != ax_dest_i) return 0;
    end
    return (mcnt[s] + int'(ax_rep_coeff_i)) <= 4;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 4; i++) begin
      mcnt[i] = 0;
      mmc[i]  = 0;
      mdst[i] = 0;
      msel[i] = 0;
    end
    mode = 0;
    merr = 0;
  endfunction

  function automatic void m_update();
    bit e, push, pop;
    int s, r, old_r;
    if (rst_i) begin
      m_clear();
      return;
    end
    e     = m_elig();
    push  = ax_valid_i && e && ax_ready_i;
    pop   = rsp_valid_i && rsp_ready_i && rsp_last_i;
    s     = int'(ax_id_i) % 4;
    r     = int'(rsp_id_i) % 4;
    old_r = mcnt[r];
    case (mode)
      0: if (flush_i) mode = 1;
      1: if (m_idle()) mode = 2;
      default: if (!flush_i) mode = 0;
    endcase
    if (push) begin
      if (mcnt[s] == 0) begin
        mmc[s]  = ax_mcast_i;
        mdst[s] = ax_dest_i;
        msel[s] = ax_select_i;
      end
      mcnt[s] += int'(ax_rep_coeff_i);
    end
    merr = pop && (old_r == 0);
    if (pop && old_r != 0) mcnt[r] -= 1;
  endfunction

  // compare every cycle, then advance DUT and model together
  task automatic step();
    bit e;
    #1;
    e = m_elig();
    chk("ax_valid_o", int'(ax_valid_o), int'(ax_valid_i && e));
    chk("ax_ready_o", int'(ax_ready_o), int'(e && ax_ready_i));
    chk("stall_o", int'(stall_o), int'(ax_valid_i && !e));
    chk("idle_o", int'(idle_o), int'(m_idle()));
    chk("err_o", int'(err_o), int'(merr));
    chk("rsp_valid_o", int'(rsp_valid_o), int'(rsp_valid_i));
    chk("rsp_ready_o", int'(rsp_ready_o), int'(rsp_ready_i));
    @(posedge clk_i);
    m_update();
    @(negedge clk_i);
  endtask

  task automatic quiet();
    ax_valid_i = 0; ax_id_i = 0; ax_mcast_i = 0;
    ax_dest_i = 0; ax_select_i = 0; ax_rep_coeff_i = 0;
    ax_ready_i = 1; rsp_valid_i = 0; rsp_id_i = 0;
    rsp_last_i = 0; rsp_ready_i = 1; flush_i = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst_i = 1;
    step();
    rst_i = 0;
  endtask

  task automatic req(int id, bit mc, int d, int sl, int rp);
    ax_valid_i = 1; ax_id_i = 4'(id); ax_mcast_i = mc;
    ax_dest_i = 4'(d); ax_select_i = 4'(sl);
    ax_rep_coeff_i = 3'(rp);
  endtask

  task automatic rsp(int id);
    rsp_valid_i = 1; rsp_ready_i = 1;
    rsp_last_i = 1; rsp_id_i = 4'(id);
  endtask

  task automatic no_rsp();
    rsp_valid_i = 0; rsp_last_i = 0;
  endtask

  initial begin
    quiet();
    rst_i = 1;
    m_clear();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 0;
    #1;
    chk("rst_idle", int'(idle_o), 1);
    chk("rst_err", int'(err_o), 0);
    chk("rst_axv", int'(ax_valid_o), 0);

    // unicast slot bound to dest 2 blocks dest 5
    do_reset();
    req(3, 0, 2, 0, 1);
    repeat (3) step();
    chk("s1_cnt", mcnt[3], 3);
    req(3, 0, 5, 0, 1);
    for (int k = 0; k < 3; k++) begin
      rsp(3);
      #1;
      chk("s1_stall", int'(stall_o), 1);
      step();
    end
    no_rsp();
    #1;
    chk("s1_go_stall", int'(stall_o), 0);
    chk("s1_go_ready", int'(ax_ready_o), 1);
    step();
    chk("s1_newdst", int'(mdst[3]), 5);

    // multicast with rep 2
    do_reset();
    req(1, 1, 0, 6, 2);
    step();
    quiet();
    chk("s2_cnt2", mcnt[1], 2);
    rsp(1);
    step();
    chk("s2_cnt1", mcnt[1], 1);
    chk("s2_busy", int'(idle_o), 0);
    step();
    no_rsp();
    chk("s2_idle", int'(idle_o), 1);

    // capacity limit with a same-cycle pop
    do_reset();
    req(0, 0, 1, 0, 3);
    step();
    req(0, 0, 1, 0, 2);
    rsp(0);
    #1;
    chk("s3_block", int'(ax_ready_o), 0);
    step();
    no_rsp();
    #1;
    chk("s3_accept", int'(ax_ready_o), 1);
    step();
    quiet();
    chk("s3_cnt", mcnt[0], 4);

    // push and pop on one slot in one cycle
    do_reset();
    req(0, 0, 3, 0, 2);
    step();
    req(0, 0, 3, 0, 1);
    rsp(0);
    step();
    quiet();
    chk("s4_cnt", mcnt[0], 2);

    // pop on an empty slot
    do_reset();
    rsp(7);
    step();
    no_rsp();
    chk("s5_err", int'(err_o), 1);
    chk("s5_idle", int'(idle_o), 1);
    step();
    chk("s5_err_off", int'(err_o), 0);

    // flush drains outstanding responses
    do_reset();
    req(2, 0, 4, 0, 2);
    step();
    quiet();
    flush_i = 1;
    step();
    req(5, 0, 1, 0, 1);
    #1;
    chk("s6_stall", int'(stall_o), 1);
    rsp(2);
    step();
    step();
    no_rsp();
    chk("s6_idle", int'(idle_o), 1);
    step();
    chk("s6_done", mode, 2);
    #1;
    chk("s6_done_stall", int'(stall_o), 1);
    flush_i = 0;
    step();
    #1;
    chk("s6_run_ready", int'(ax_ready_o), 1);
    step();

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_i          = ($urandom_range(0, 199) == 0);
      ax_valid_i     = $urandom_range(0, 1);
      ax_id_i        = 4'($urandom_range(0, 15));
      ax_mcast_i     = $urandom_range(0, 1);
      ax_dest_i      = 4'($urandom_range(0, 2));
      ax_select_i    = 4'($urandom_range(0, 2));
      ax_rep_coeff_i = 3'($urandom_range(0, 5));
      ax_ready_i     = ($urandom_range(0, 3) != 0);
      rsp_valid_i    = $urandom_range(0, 1);
      rsp_ready_i    = ($urandom_range(0, 3) != 0);
      rsp_last_i     = ($urandom_range(0, 2) != 0);
      rsp_id_i       = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) flush_i = ~flush_i;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
